// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: address map defaults,
// peripheral register offsets and the byte-lane merge helper.
package dmem_responder_pkg;

    localparam int          RAM_AW_DFLT      = 12;
    localparam logic [31:0] RAM_BASE_DFLT    = 32'h0001_0000;
    localparam logic [31:0] PERIPH_BASE_DFLT = 32'h0002_0000;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Word offsets within the peripheral page (byte address bits [7:2]).
    typedef enum logic [5:0] {
        PR_MTIME_LO    = 6'h00,
        PR_MTIME_HI    = 6'h01,
        PR_MTIMECMP_LO = 6'h02,
        PR_MTIMECMP_HI = 6'h03,
        PR_TOHOST      = 6'h04
    } periph_reg_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  ben);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = ben[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/dmem_responder_mtimer.sv
// Machine timer: prescaled 64-bit mtime, mtimecmp, byte-merged register
// writes and the registered mtime >= mtimecmp interrupt.
module dmem_responder_mtimer
    import dmem_responder_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        i_wen,
    input  logic [5:0]  i_reg,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_ben,
    output logic [63:0] o_mtime,
    output logic [63:0] o_mtimecmp,
    output logic        o_irq
);

    localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [63:0]   r_mtime;
    logic [63:0]   r_mtimecmp;
    logic          r_irq;

    logic w_tick, w_wr_lo, w_wr_hi, w_wr_clo, w_wr_chi;

    assign w_tick   = (r_presc == PRESC_MAX);
    assign w_wr_lo  = i_wen && (i_reg == PR_MTIME_LO);
    assign w_wr_hi  = i_wen && (i_reg == PR_MTIME_HI);
    assign w_wr_clo = i_wen && (i_reg == PR_MTIMECMP_LO);
    assign w_wr_chi = i_wen && (i_reg == PR_MTIMECMP_HI);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_presc    <= '0;
            r_mtime    <= '0;
            r_mtimecmp <= MTIMECMP_RST;
            r_irq      <= 1'b0;
        end else begin
            r_irq <= (r_mtime >= r_mtimecmp);

            // A software write to either mtime half suppresses this cycle's tick
            // and restarts the prescaler so the new value gets a full period.
            if (w_wr_lo || w_wr_hi) begin
                r_presc <= '0;
                if (w_wr_lo) r_mtime[31:0]  <= byte_merge(r_mtime[31:0],  i_wdata, i_ben);
                if (w_wr_hi) r_mtime[63:32] <= byte_merge(r_mtime[63:32], i_wdata, i_ben);
            end else if (w_tick) begin
                r_presc <= '0;
                r_mtime <= r_mtime + 64'd1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            if (w_wr_clo) r_mtimecmp[31:0]  <= byte_merge(r_mtimecmp[31:0],  i_wdata, i_ben);
            if (w_wr_chi) r_mtimecmp[63:32] <= byte_merge(r_mtimecmp[63:32], i_wdata, i_ben);
        end
    end

    assign o_mtime    = r_mtime;
    assign o_mtimecmp = r_mtimecmp;
    assign o_irq      = r_irq;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: decodes core dmem accesses onto a byte-writable RAM,
// the machine timer and the tohost exit register; flags unmapped accesses.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          RAM_AW      = RAM_AW_DFLT,
    parameter logic [31:0] RAM_BASE    = RAM_BASE_DFLT,
    parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DFLT,
    parameter int          TICK_DIV    = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    input  logic        dmem_wen_i,
    input  logic [3:0]  dmem_ben_i,
    output logic [31:0] dmem_rdata_o,
    output logic        timer_irq_o,
    output logic        halt_o,
    output logic [30:0] exit_code_o,
    output logic        bus_err_o
);

    logic              w_ram_hit, w_per_hit, w_per_wen, w_tohost_wr;
    logic [RAM_AW-1:0] w_idx;
    logic [5:0]        w_reg;
    logic [31:0]       w_tohost_nxt;
    logic [31:0]       w_rdata;
    logic [63:0]       w_mtime, w_mtimecmp;
    logic              w_unused;

    logic [31:0] r_ram [0:(1<<RAM_AW)-1];
    logic [31:0] r_tohost;
    logic        r_halt;
    logic [30:0] r_exit;
    logic        r_bus_err;

    // RAM_BASE is aligned to the RAM size, so an upper-bit match is the range check.
    assign w_ram_hit   = (dmem_addr_i[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]);
    assign w_per_hit   = (dmem_addr_i[31:8] == PERIPH_BASE[31:8]);
    assign w_idx       = dmem_addr_i[RAM_AW+1:2];
    assign w_reg       = dmem_addr_i[7:2];
    assign w_per_wen   = w_per_hit && dmem_wen_i;
    assign w_tohost_wr = w_per_wen && (w_reg == PR_TOHOST);
    assign w_tohost_nxt = byte_merge(r_tohost, dmem_wdata_i, dmem_ben_i);
    assign w_unused    = ^dmem_addr_i[1:0];

    // No reset on the array; the write is gated so a store in a reset cycle is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && w_ram_hit && dmem_wen_i) begin
            for (int b = 0; b < 4; b++)
                if (dmem_ben_i[b]) r_ram[w_idx][8*b +: 8] <= dmem_wdata_i[8*b +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_tohost  <= '0;
            r_halt    <= 1'b0;
            r_exit    <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= !(w_ram_hit || w_per_hit);
            if (w_tohost_wr) begin
                r_tohost <= w_tohost_nxt;
                if (!r_halt && (w_tohost_nxt != 32'd0)) begin
                    r_halt <= 1'b1;
                    r_exit <= w_tohost_nxt[31:1];
                end
            end
        end
    end

    dmem_responder_mtimer #(
        .TICK_DIV (TICK_DIV)
    ) u_mtimer (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .i_wen      (w_per_wen),
        .i_reg      (w_reg),
        .i_wdata    (dmem_wdata_i),
        .i_ben      (dmem_ben_i),
        .o_mtime    (w_mtime),
        .o_mtimecmp (w_mtimecmp),
        .o_irq      (timer_irq_o)
    );

    always_comb begin
        w_rdata = '0;
        if (w_ram_hit) begin
            w_rdata = r_ram[w_idx];
        end else if (w_per_hit) begin
            case (w_reg)
                PR_MTIME_LO:    w_rdata = w_mtime[31:0];
                PR_MTIME_HI:    w_rdata = w_mtime[63:32];
                PR_MTIMECMP_LO: w_rdata = w_mtimecmp[31:0];
                PR_MTIMECMP_HI: w_rdata = w_mtimecmp[63:32];
                PR_TOHOST:      w_rdata = r_tohost;
                default:        w_rdata = '0;
            endcase
        end
    end

    assign dmem_rdata_o = w_rdata;
    assign halt_o       = r_halt;
    assign exit_code_o  = r_exit;
    assign bus_err_o    = r_bus_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: load results are queued as stimulus
// is driven and compared when the combinational read data is sampled.
module tb_dmem_responder;

    localparam logic [31:0] RB = 32'h0001_0000;
    localparam logic [31:0] PB = 32'h0002_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, wdata, rdata;
    logic        wen;
    logic [3:0]  ben;
    logic        irq, halt, bus_err;
    logic [30:0] exit_code;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    dmem_responder #(
        .RAM_AW      (12),
        .RAM_BASE    (RB),
        .PERIPH_BASE (PB),
        .TICK_DIV    (4)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .dmem_addr_i  (addr),
        .dmem_wdata_i (wdata),
        .dmem_wen_i   (wen),
        .dmem_ben_i   (ben),
        .dmem_rdata_o (rdata),
        .timer_irq_o  (irq),
        .halt_o       (halt),
        .exit_code_o  (exit_code),
        .bus_err_o    (bus_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        addr = RB; wen = 1'b0; ben = 4'hF; wdata = '0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a; wdata = d; wen = 1'b1; ben = b;
        cyc();
        idle();
    endtask

    task automatic ld(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a; wen = 1'b0; ben = 4'hF;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        chk(tag_q.pop_front(), {32'd0, rdata}, {32'd0, exp_q.pop_front()});
        @(posedge clk); #1;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        rst_n = 1'b0;
        idle();
        cyc(); cyc();
        @(negedge clk);
        chk("rst_irq", {63'd0, irq}, 64'd0);
        chk("rst_halt", {63'd0, halt}, 64'd0);
        chk("rst_exit", {33'd0, exit_code}, 64'd0);
        chk("rst_buserr", {63'd0, bus_err}, 64'd0);
        cyc();
        ld("rst_mtimecmp_lo", PB + 32'h8, 32'hFFFF_FFFF);
        rst_n = 1'b1;

        // Timer: 40 cycles at TICK_DIV=4 gives 10 ticks.
        repeat (40) cyc();
        ld("mtime_after40", PB + 32'h0, 32'd10);
        st(PB + 32'hC, 32'd0, 4'hF);
        st(PB + 32'h8, 32'd12, 4'hF);
        k = -1;
        for (int i = 0; i < 40 && k < 0; i++) begin
            addr = PB;
            @(negedge clk);
            if (rdata == 32'd12) begin
                k = i;
                chk("irq_at_reach", {63'd0, irq}, 64'd0);
            end
            cyc();
        end
        if (k < 0) chk("mtime_reach12", 64'd0, 64'd1);
        else begin
            @(negedge clk);
            chk("irq_rise", {63'd0, irq}, 64'd1);
            cyc();
        end
        idle();
        st(PB + 32'hC, 32'd1, 4'hF);
        @(negedge clk);
        chk("irq_hold_1cyc", {63'd0, irq}, 64'd1);
        cyc();
        @(negedge clk);
        chk("irq_drop", {63'd0, irq}, 64'd0);
        cyc();

        // RAM byte lanes and edges.
        st(RB + 32'h4, 32'hDEAD_BEEF, 4'hF);
        st(RB + 32'h4, 32'h0000_5500, 4'b0010);
        ld("ram_lane_merge", RB + 32'h4, 32'hDEAD_55EF);
        st(RB + 32'h4, 32'h1234_5678, 4'h0);
        ld("ram_ben0_noop", RB + 32'h4, 32'hDEAD_55EF);
        st(RB + 32'h3FFC, 32'hCAFE_F00D, 4'hF);
        ld("ram_last_word", RB + 32'h3FFC, 32'hCAFE_F00D);
        st(RB + 32'h0, 32'hA5A5_A5A5, 4'hF);

        // Unmapped accesses.
        addr = 32'h0; wen = 1'b0; ben = 4'hF;
        exp_q.push_back(32'd0); tag_q.push_back("unmapped_rdata");
        @(negedge clk);
        chk(tag_q.pop_front(), {32'd0, rdata}, {32'd0, exp_q.pop_front()});
        chk("buserr_same_cyc", {63'd0, bus_err}, 64'd0);
        cyc(); idle();
        @(negedge clk);
        chk("buserr_pulse", {63'd0, bus_err}, 64'd1);
        cyc();
        @(negedge clk);
        chk("buserr_clear", {63'd0, bus_err}, 64'd0);
        cyc();
        st(32'h0, 32'hFFFF_FFFF, 4'hF);
        ld("unmapped_store_drop", RB + 32'h0, 32'hA5A5_A5A5);
        ld("ram_end_unmapped", RB + 32'h4000, 32'd0);
        @(negedge clk);
        chk("ram_end_buserr", {63'd0, bus_err}, 64'd1);
        cyc();
        st(PB + 32'h14, 32'h1111_1111, 4'hF);
        ld("periph_unused_off", PB + 32'h14, 32'd0);
        chk("periph_no_buserr", {63'd0, bus_err}, 64'd0);

        // Store colliding with an increment edge wins; hi holds.
        st(PB + 32'h4, 32'd0, 4'hF);
        st(PB + 32'h0, 32'hFFFF_FFFF, 4'hF);
        repeat (3) cyc();
        st(PB + 32'h0, 32'd5, 4'hF);
        ld("collide_lo", PB + 32'h0, 32'd5);
        ld("collide_hi", PB + 32'h4, 32'd0);
        st(PB + 32'h4, 32'd0, 4'hF);
        st(PB + 32'h0, 32'hFFFF_FFFF, 4'hF);
        repeat (4) cyc();
        ld("carry_hi", PB + 32'h4, 32'd1);
        ld("carry_lo", PB + 32'h0, 32'd0);

        // tohost / halt.
        chk("halt_before", {63'd0, halt}, 64'd0);
        st(PB + 32'h10, 32'd7, 4'hF);
        @(negedge clk);
        chk("halt_set", {63'd0, halt}, 64'd1);
        chk("exit_code", {33'd0, exit_code}, 64'd3);
        cyc();
        st(PB + 32'h10, 32'd1, 4'hF);
        ld("tohost_readback", PB + 32'h10, 32'd1);
        chk("exit_sticky", {33'd0, exit_code}, 64'd3);

        // Reset mid-run with a colliding store.
        st(PB + 32'hC, 32'd0, 4'hF);
        st(PB + 32'h8, 32'd0, 4'hF);
        cyc();
        @(negedge clk);
        chk("irq_pre_reset", {63'd0, irq}, 64'd1);
        cyc();
        addr = PB + 32'h8; wdata = 32'h55; wen = 1'b1; ben = 4'hF; rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; idle();
        addr = PB;
        @(negedge clk);
        chk("post_rst_mtime", {32'd0, rdata}, 64'd0);
        chk("post_rst_irq", {63'd0, irq}, 64'd0);
        chk("post_rst_halt", {63'd0, halt}, 64'd0);
        chk("post_rst_exit", {33'd0, exit_code}, 64'd0);
        chk("post_rst_buserr", {63'd0, bus_err}, 64'd0);
        cyc(); idle();
        ld("post_rst_cmp_lo", PB + 32'h8, 32'hFFFF_FFFF);
        ld("post_rst_cmp_hi", PB + 32'hC, 32'hFFFF_FFFF);
        ld("post_rst_tohost", PB + 32'h10, 32'd0);
        ld("post_rst_ram", RB + 32'h4, 32'hDEAD_55EF);
        addr = RB + 32'h4; wdata = 32'h0; wen = 1'b1; ben = 4'hF; rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; idle();
        ld("rst_ram_wr_blocked", RB + 32'h4, 32'hDEAD_55EF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
